// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a small transmit FIFO.
// Everything runs on clk. A divider produces a one-cycle enable at the end of each bit period.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 we,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 overflow,
  output logic                 tx
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = 4;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // ---------------- transmit FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic                 full_reg, empty_reg, overflow_reg;
  logic                 wr_en, pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  assign wr_en      = we & ~full_reg;
  assign head       = mem[rd_ptr_reg];
  assign count_next = count_reg + CNT_W'(wr_en) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= data;
    end
  end

  // A write into a full FIFO is lost even if a pop frees a slot on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_CNT);
      empty_reg <= (count_next == '0);
      if (we && full_reg) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Parity of the head word, computed as it is popped.
  logic [DATA_BITS:0] xor_chain;
  assign xor_chain[0] = 1'b0;
  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_par
    assign xor_chain[gi+1] = xor_chain[gi] ^ head[gi];
  end
  assign head_par = (PARITY == 1) ? ~xor_chain[DATA_BITS] : xor_chain[DATA_BITS];

  // ---------------- frame sequencer ----------------
  state_t               state_reg, state_next;
  logic [DIV_W-1:0]     div_reg, div_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 tx_reg, tx_next;
  logic                 busy_reg, busy_next;
  logic                 tick;

  assign tick = (div_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      div_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    pop        = 1'b0;

    if (state_reg != ST_IDLE) begin
      div_next = tick ? '0 : div_reg + DIV_W'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        div_next = '0;
        if (!empty_reg) begin
          pop        = 1'b1;
          shift_next = head;
          par_next   = head_par;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
          bit_next   = '0;
          state_next = ST_START;
        end
      end

      ST_START: begin
        if (tick) begin
          state_next = ST_DATA;
          tx_next    = shift_reg[0];
          bit_next   = '0;
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
            if (PARITY != 0) begin
              state_next = ST_PARITY;
              tx_next    = par_reg;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + BIT_W'(1);
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          state_next = ST_STOP;
          tx_next    = 1'b1;
          bit_next   = '0;
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (bit_reg == STOP_LAST) begin
            bit_next = '0;
            // Chain straight into the next start bit when more words are waiting.
            if (!empty_reg) begin
              pop        = 1'b1;
              shift_next = head;
              par_next   = head_par;
              tx_next    = 1'b0;
              state_next = ST_START;
            end else begin
              busy_next  = 1'b0;
              state_next = ST_IDLE;
            end
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign tx       = tx_reg;
  assign busy     = busy_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: four instances cover the parity, stop-bit and width variants.
// Stimulus pushes expected frames; one monitor per instance decodes tx cycle by cycle.
module tb_uart_tx_fifo;

  localparam int DIV = 4;
  localparam int N   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst_v, we_v, rst_q;
  logic [7:0]   d0, d1, d2;
  logic [6:0]   d3;
  wire  [N-1:0] tx_v, busy_v, full_v, empty_v, ovf_v;
  int           cyc = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_v;
  end

  // 0: 8N1   1: 8E1   2: 8O1   3: 7N2
  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst_v[0]), .data(d0), .we(we_v[0]), .full(full_v[0]), .empty(empty_v[0]),
    .busy(busy_v[0]), .overflow(ovf_v[0]), .tx(tx_v[0]));
  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
    .clk(clk), .rst(rst_v[1]), .data(d1), .we(we_v[1]), .full(full_v[1]), .empty(empty_v[1]),
    .busy(busy_v[1]), .overflow(ovf_v[1]), .tx(tx_v[1]));
  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_o (
    .clk(clk), .rst(rst_v[2]), .data(d2), .we(we_v[2]), .full(full_v[2]), .empty(empty_v[2]),
    .busy(busy_v[2]), .overflow(ovf_v[2]), .tx(tx_v[2]));
  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_s (
    .clk(clk), .rst(rst_v[3]), .data(d3), .we(we_v[3]), .full(full_v[3]), .empty(empty_v[3]),
    .busy(busy_v[3]), .overflow(ovf_v[3]), .tx(tx_v[3]));

  function automatic int db_of(int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic int sb_of(int i);
    return (i == 3) ? 2 : 1;
  endfunction

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   frame_cnt [N] = '{default: 0};
  int   frame_start [N][16];

  task automatic check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // ---------------- monitors ----------------
  for (genvar gi = 0; gi < N; gi++) begin : g_mon
    exp_t e;
    int   idx, nb, errs, bad_bit, t0;
    logic bits [16];
    bit   aborted;

    initial begin
      forever begin
        @(negedge clk);
        if (rst_q[gi] === 1'b0 && tx_v[gi] === 1'b0) begin
          t0  = cyc;
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++) begin
            if (idx < 0 && exp_q[k].inst == gi) idx = k;
          end
          if (idx < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame%0d: unexpected start bit at cycle %0d, expected no frame", gi, t0);
            e.inst = gi;
            e.data = '0;
            e.par  = 1'b0;
          end else begin
            e = exp_q[idx];
            exp_q.delete(idx);
          end
          bits[0] = 1'b0;
          for (int d = 0; d < db_of(gi); d++) bits[1+d] = e.data[d];
          nb = 1 + db_of(gi);
          if (par_of(gi) != 0) begin
            bits[nb] = e.par;
            nb++;
          end
          for (int s = 0; s < sb_of(gi); s++) begin
            bits[nb] = 1'b1;
            nb++;
          end
          errs    = 0;
          bad_bit = -1;
          aborted = 1'b0;
          for (int b = 0; b < nb && !aborted; b++) begin
            for (int c = 0; c < DIV && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst_q[gi] !== 1'b0) begin
                aborted = 1'b1;
              end else if (tx_v[gi] !== bits[b] || busy_v[gi] !== 1'b1) begin
                errs++;
                if (bad_bit < 0) bad_bit = b;
              end
            end
          end
          if (!aborted && idx >= 0) begin
            n_tests++;
            if (errs != 0) begin
              n_fail++;
              $display("FAIL frame%0d data=%02h: %0d bad cycles (first at bit %0d), expected 0",
                       gi, e.data, errs, bad_bit);
            end else begin
              $display("[TB] frame%0d data=%02h par=%0d start=%0d ok", gi, e.data, e.par, t0);
            end
            if (frame_cnt[gi] < 16) frame_start[gi][frame_cnt[gi]] = t0;
            frame_cnt[gi]++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(int i, logic [7:0] d, logic w);
    case (i)
      0:       d0 = d;
      1:       d1 = d;
      2:       d2 = d;
      default: d3 = d[6:0];
    endcase
    we_v[i] = w;
  endtask

  task automatic push(int i, logic [7:0] d, logic p);
    exp_t x;
    x.inst = i;
    x.data = d;
    x.par  = p;
    exp_q.push_back(x);
  endtask

  task automatic write1(int i, logic [7:0] d, logic p);
    drive(i, d, 1'b1);
    push(i, d, p);
    @(negedge clk);
    we_v[i] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busy_len(int i, int win, int req, string name);
    int n = 0;
    repeat (win) begin
      @(negedge clk);
      if (busy_v[i]) n++;
    end
    check(name, n, req);
  endtask

  logic [7:0] burst [6];
  logic [7:0] rv [3];
  int base, t_k;

  initial begin
    burst = '{8'h01, 8'h80, 8'hA5, 8'h3C, 8'hFF, 8'hEE};
    rv    = '{8'h12, 8'h34, 8'h56};
    rst_v = '1;
    we_v  = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    idle(3);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset%0d {tx,busy,full,empty,ovf}", i),
            {tx_v[i], busy_v[i], full_v[i], empty_v[i], ovf_v[i]}, 5'b10010);
    end
    rst_v = '0;
    idle(2);

    // 8N1 frame of 0x55
    write1(0, 8'h55, 1'b0);
    busy_len(0, 60, 40, "t1 busy cycles");
    check("t1 tx idle after frame", tx_v[0], 1);
    check("t1 frames", frame_cnt[0], 1);

    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    write1(1, 8'h07, 1'b1);
    busy_len(1, 60, 44, "t2 even busy cycles");
    write1(2, 8'h07, 1'b0);
    busy_len(2, 60, 44, "t2 odd busy cycles");

    // 7 data bits, 2 stop bits
    write1(3, 8'h7F, 1'b0);
    busy_len(3, 60, 40, "t4 busy cycles");
    check("t4 tx idle after frame", tx_v[3], 1);

    // burst of six: first pops immediately, four fill the FIFO, sixth is dropped
    base = frame_cnt[0];
    for (int i = 0; i < 6; i++) begin
      drive(0, burst[i], 1'b1);
      if (i < 5) push(0, burst[i], 1'b0);
      @(negedge clk);
      if (i == 4) begin
        check("t3 full after 5 writes", full_v[0], 1);
        check("t3 ovf before 6th", ovf_v[0], 0);
      end
    end
    we_v[0] = 1'b0;
    check("t3 ovf after 6th", ovf_v[0], 1);
    check("t3 full after 6th", full_v[0], 1);
    idle(5 * 40 + 20);
    check("t3 frames", frame_cnt[0] - base, 5);
    for (int f = 0; f < 4; f++) begin
      check($sformatf("t3 spacing %0d", f),
            frame_start[0][base+f+1] - frame_start[0][base+f], 40);
    end
    check("t3 busy after burst", busy_v[0], 0);
    check("t3 empty after burst", empty_v[0], 1);
    check("t3 ovf sticky", ovf_v[0], 1);

    // reset during data bit 3 with two words still queued
    base = frame_cnt[0];
    for (int i = 0; i < 3; i++) begin
      drive(0, rv[i], 1'b1);
      if (i == 0) push(0, rv[i], 1'b0);
      @(negedge clk);
    end
    we_v[0] = 1'b0;
    idle(15);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check("t5 tx after reset", tx_v[0], 1);
    check("t5 busy after reset", busy_v[0], 0);
    check("t5 empty after reset", empty_v[0], 1);
    check("t5 ovf after reset", ovf_v[0], 0);
    check("t5 full after reset", full_v[0], 0);
    idle(100);
    check("t5 no further frames", frame_cnt[0] - base, 0);

    // write-to-start latency, and a word queued during the stop bit
    base = frame_cnt[0];
    drive(0, 8'hA3, 1'b1);
    push(0, 8'hA3, 1'b0);
    @(negedge clk);
    we_v[0] = 1'b0;
    t_k = cyc;
    check("t6 empty after write edge", empty_v[0], 0);
    check("t6 tx idle after write edge", tx_v[0], 1);
    @(negedge clk);
    check("t6 tx start after k+1", tx_v[0], 0);
    check("t6 busy after k+1", busy_v[0], 1);
    check("t6 empty after pop", empty_v[0], 1);
    idle(36);
    check("t6 tx in stop bit", tx_v[0], 1);
    write1(0, 8'h5A, 1'b0);
    idle(90);
    check("t6 frames", frame_cnt[0] - base, 2);
    check("t6 first start cycle", frame_start[0][base] - t_k, 1);
    check("t6 back-to-back spacing", frame_start[0][base+1] - frame_start[0][base], 40);
    check("t6 busy at end", busy_v[0], 0);

    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
